// File: rtl/router_pkg.sv
// Shared router definitions: port indices, one-hot priority constants and scheduler state.
// Used by the output scheduler, the input buffers and the crossbar.
package router_pkg;
  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  localparam logic [IDX_W-1:0] PORT0 = 2'd0;
  localparam logic [IDX_W-1:0] PORT1 = 2'd1;
  localparam logic [IDX_W-1:0] PORT2 = 2'd2;
  localparam logic [IDX_W-1:0] PORT3 = 2'd3;

  localparam logic [NUM_REQ-1:0] P0 = 4'b0001;
  localparam logic [NUM_REQ-1:0] P1 = 4'b0010;
  localparam logic [NUM_REQ-1:0] P2 = 4'b0100;
  localparam logic [NUM_REQ-1:0] P3 = 4'b1000;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    LOCKED = 2'b01
  } sched_state_t;

  function automatic logic onehot4(input logic [NUM_REQ-1:0] v);
    return (v != '0) && ((v & (v - 4'd1)) == '0);
  endfunction

  // Priority moves to the requester just after the winner (3 wraps to 0).
  function automatic logic [NUM_REQ-1:0] rotl1(input logic [NUM_REQ-1:0] v);
    return {v[NUM_REQ-2:0], v[NUM_REQ-1]};
  endfunction
endpackage

// File: rtl/output_port_scheduler_rr_pick.sv
// Combinational 4-way rotating-priority picker: first set req bit at or above the
// one-hot prio position, wrapping 3->0. Also usable by the switch allocator.
module rr_pick
  import router_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] prio,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);
  logic [IDX_W-1:0] start;
  logic [IDX_W-1:0] pos;
  logic             found;

  always_comb begin
    start = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (prio[i]) start = IDX_W'(i);
  end

  // 2-bit index arithmetic wraps naturally, giving the 3->0 scan order.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    pos   = '0;
    found = 1'b0;
    any   = |req;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = start + IDX_W'(k);
      if (!found && req[pos]) begin
        gnt[pos] = 1'b1;
        idx      = pos;
        found    = 1'b1;
      end
    end
  end
endmodule

// File: rtl/output_port_scheduler.sv
// Per-output-port wormhole scheduler: round-robin packet grant among 4 input buffers,
// gated by a downstream credit counter.
module output_port_scheduler
  import router_pkg::*;
#(
  parameter int CREDITS = 4,
  parameter int CNT_W   = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         req,
  input  logic [3:0]         flit_tail,
  input  logic               credit_in,
  output logic [3:0]         grant,
  output logic [1:0]         grant_id,
  output logic               xfer,
  output logic               busy,
  output logic [CNT_W-1:0]   credit_cnt,
  output logic               credit_err
);
  localparam logic [CNT_W-1:0] CRED_MAX = CNT_W'(CREDITS);

  sched_state_t       state, state_nxt;
  logic [NUM_REQ-1:0] prio, prio_nxt, prio_safe;
  logic [IDX_W-1:0]   owner, owner_nxt;
  logic [NUM_REQ-1:0] pick_gnt;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic               can_send;

  assign can_send  = (credit_cnt != '0);
  assign prio_safe = onehot4(prio) ? prio : P0;

  rr_pick u_pick (
    .req  (req),
    .prio (prio_safe),
    .gnt  (pick_gnt),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      prio  <= P0;
      owner <= PORT0;
    end else begin
      state <= state_nxt;
      prio  <= prio_nxt;
      owner <= owner_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    prio_nxt  = prio_safe;
    owner_nxt = owner;
    case (state)
      IDLE: begin
        if (xfer) begin
          prio_nxt = rotl1(grant);
          if (!flit_tail[grant_id]) begin
            state_nxt = LOCKED;
            owner_nxt = grant_id;
          end
        end
      end
      LOCKED: begin
        if (xfer && flit_tail[owner]) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are held low for the whole time reset is asserted, not just after an edge.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    busy     = 1'b0;
    if (rst) begin
      case (state)
        IDLE: begin
          if (pick_any && can_send) begin
            grant    = pick_gnt;
            grant_id = pick_idx;
          end
        end
        LOCKED: begin
          busy = 1'b1;
          if (req[owner] && can_send) begin
            grant    = NUM_REQ'(1) << owner;
            grant_id = owner;
          end
        end
        default: ;
      endcase
    end
  end

  assign xfer = |grant;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      credit_cnt <= CRED_MAX;
      credit_err <= 1'b0;
    end else begin
      case ({xfer, credit_in})
        2'b10: credit_cnt <= credit_cnt - 1'b1;
        2'b01: begin
          if (credit_cnt == CRED_MAX) credit_err <= 1'b1;
          else                        credit_cnt <= credit_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_output_port_scheduler.sv
// Scoreboard bench: stimulus pushes the expected per-cycle outputs, a negedge monitor
// pops and compares them against the scheduler.
module tb_output_port_scheduler;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] req = '0;
  logic [3:0] flit_tail = '0;
  logic       credit_in = 1'b0;
  logic [3:0] grant;
  logic [1:0] grant_id;
  logic       xfer;
  logic       busy;
  logic [2:0] credit_cnt;
  logic       credit_err;

  output_port_scheduler #(.CREDITS(4), .CNT_W(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .flit_tail  (flit_tail),
    .credit_in  (credit_in),
    .grant      (grant),
    .grant_id   (grant_id),
    .xfer       (xfer),
    .busy       (busy),
    .credit_cnt (credit_cnt),
    .credit_err (credit_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [3:0] g;
    logic       b;
    logic [2:0] c;
    logic       e;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  task automatic chk(input string nm, input int c, input int act, input int expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, c, act, expv);
    end
  endtask

  function automatic int onehot_idx(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return 0;
  endfunction

  // Monitor: one expected record per driven cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t x;
      x = exp_q.pop_front();
      chk("grant",      x.cyc, int'(grant),      int'(x.g));
      chk("grant_id",   x.cyc, int'(grant_id),   onehot_idx(x.g));
      chk("xfer",       x.cyc, int'(xfer),       int'(x.g != 0));
      chk("busy",       x.cyc, int'(busy),       int'(x.b));
      chk("credit_cnt", x.cyc, int'(credit_cnt), int'(x.c));
      chk("credit_err", x.cyc, int'(credit_err), int'(x.e));
    end
  end

  task automatic step(input logic r, input logic [3:0] rq, input logic [3:0] tl,
                      input logic ci, input logic [3:0] eg, input logic eb,
                      input logic [2:0] ec, input logic ee);
    exp_t x;
    @(posedge clk);
    #1;
    rst = r; req = rq; flit_tail = tl; credit_in = ci;
    cyc++;
    x.cyc = cyc; x.g = eg; x.b = eb; x.c = ec; x.e = ee;
    exp_q.push_back(x);
  endtask

  initial begin
    // reset holds grant low even with all requests up
    step(0, 4'b1111, 4'b1111, 0, 4'b0000, 0, 4, 0);
    // single-flit round robin, credit returned every transfer
    step(1, 4'b1111, 4'b1111, 1, 4'b0001, 0, 4, 0);
    step(1, 4'b1111, 4'b1111, 1, 4'b0010, 0, 4, 0);
    step(1, 4'b1111, 4'b1111, 1, 4'b0100, 0, 4, 0);
    step(1, 4'b1111, 4'b1111, 1, 4'b1000, 0, 4, 0);
    step(1, 4'b1111, 4'b1111, 1, 4'b0001, 0, 4, 0);
    // bring prio back to requester 0
    step(1, 4'b1000, 4'b1111, 1, 4'b1000, 0, 4, 0);
    // 3-flit packet on req0 with req2 competing
    step(1, 4'b0101, 4'b0100, 1, 4'b0001, 0, 4, 0);
    step(1, 4'b0101, 4'b0100, 1, 4'b0001, 1, 4, 0);
    step(1, 4'b0101, 4'b0101, 1, 4'b0001, 1, 4, 0);
    step(1, 4'b0100, 4'b0100, 1, 4'b0100, 0, 4, 0);
    // lock on req0 then req0 drops: bubble, req2 not served
    step(1, 4'b0101, 4'b0100, 1, 4'b0001, 0, 4, 0);
    step(1, 4'b0100, 4'b0100, 0, 4'b0000, 1, 4, 0);
    step(1, 4'b0101, 4'b0101, 1, 4'b0001, 1, 4, 0);
    // credit exhaustion on a long packet
    step(1, 4'b0001, 4'b0000, 0, 4'b0001, 0, 4, 0);
    step(1, 4'b0001, 4'b0000, 0, 4'b0001, 1, 3, 0);
    step(1, 4'b0001, 4'b0000, 0, 4'b0001, 1, 2, 0);
    step(1, 4'b0001, 4'b0000, 0, 4'b0001, 1, 1, 0);
    step(1, 4'b0001, 4'b0000, 0, 4'b0000, 1, 0, 0);
    step(1, 4'b0001, 4'b0000, 0, 4'b0000, 1, 0, 0);
    step(1, 4'b0001, 4'b0000, 1, 4'b0000, 1, 0, 0);
    step(1, 4'b0001, 4'b0000, 0, 4'b0001, 1, 1, 0);
    step(1, 4'b0001, 4'b0000, 1, 4'b0000, 1, 0, 0);
    step(1, 4'b0001, 4'b0000, 1, 4'b0001, 1, 1, 0);
    step(1, 4'b0001, 4'b0001, 0, 4'b0001, 1, 1, 0);
    // refill credits
    step(1, 4'b0000, 4'b0000, 1, 4'b0000, 0, 0, 0);
    step(1, 4'b0000, 4'b0000, 1, 4'b0000, 0, 1, 0);
    step(1, 4'b0000, 4'b0000, 1, 4'b0000, 0, 2, 0);
    step(1, 4'b0000, 4'b0000, 1, 4'b0000, 0, 3, 0);
    // overflow: sticky error, count saturates
    step(1, 4'b0000, 4'b0000, 1, 4'b0000, 0, 4, 0);
    step(1, 4'b0000, 4'b0000, 0, 4'b0000, 0, 4, 1);
    step(1, 4'b0000, 4'b0000, 0, 4'b0000, 0, 4, 1);
    // lock on req3, then reset mid-packet
    step(1, 4'b1000, 4'b0000, 1, 4'b1000, 0, 4, 1);
    step(1, 4'b1000, 4'b0000, 1, 4'b1000, 1, 4, 1);
    step(0, 4'b1000, 4'b0000, 0, 4'b0000, 0, 4, 0);
    step(1, 4'b1001, 4'b1001, 0, 4'b0001, 0, 4, 0);
    step(1, 4'b0000, 4'b0000, 0, 4'b0000, 0, 3, 0);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
